// File: rtl/register_file.sv
// register_file: 2R/1W integer register file, x0 reads zero; a clear sequencer zeroes all entries after reset.
// Latency: reads are registered, so data appears one cycle after rd_en. Writes take effect at the edge.
// Backpressure: none. Requests made while ready=0 are dropped. Optional macro REGFILE_BYPASS_EN enables write-first forwarding.
module register_file #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_en,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rd_valid,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic            ready
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     clr_ptr;
    logic              clr_active;
    logic              accept;
    logic              wr_hit;
    logic [XLEN-1:0]   mem [NREGS];
    logic [XLEN-1:0]   rd1_val;
    logic [XLEN-1:0]   rd2_val;

    // State register and clear pointer; reset restarts the clear sequence
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_INIT;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (clr_active) begin
                clr_ptr <= clr_ptr + 1'b1;
            end
        end
    end

    // Next state: leave INIT after the edge that clears the last entry
    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && clr_ptr == AW'(NREGS - 1)) begin
            state_nxt = ST_RUN;
        end
    end

    // FSM outputs: clearing during INIT, traffic accepted only in RUN
    always_comb begin
        clr_active = 1'b0;
        accept     = 1'b0;
        ready      = 1'b0;
        case (state)
            ST_INIT: clr_active = 1'b1;
            ST_RUN: begin
                accept = 1'b1;
                ready  = 1'b1;
            end
            default: begin
                clr_active = 1'b0;
            end
        endcase
    end

    assign wr_hit = accept && wr_en && (wr_addr != '0);

    // Storage update: sequencer clears during INIT, architectural writes in RUN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_active) begin
                mem[clr_ptr] <= '0;
            end else if (wr_hit) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    // Read operand selection, x0 forced to zero, optional same-edge forwarding
    always_comb begin
        rd1_val = (rs1_addr == '0) ? '0 : mem[rs1_addr];
        rd2_val = (rs2_addr == '0) ? '0 : mem[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_hit && wr_addr == rs1_addr) begin
            rd1_val = wr_data;
        end
        if (wr_hit && wr_addr == rs2_addr) begin
            rd2_val = wr_data;
        end
`else
        rd1_val = rd1_val;
        rd2_val = rd2_val;
`endif
    end

    // Registered read ports; data holds when no read is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rs1_data <= '0;
            rs2_data <= '0;
        end else begin
            rd_valid <= accept && rd_en;
            if (accept && rd_en) begin
                rs1_data <= rd1_val;
                rs2_data <= rd2_val;
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Randomized + directed bench for register_file against an array-based reference model.
// Each step drives inputs, waits one rising edge, then checks ready/rd_valid/read data.
// The model tracks clear progress as a cycle count and register contents as a plain array.
module tb_register_file;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            rd_en;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rd_valid;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            ready;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [XLEN-1:0] m_mem [NREGS];
    int              m_cnt;
    logic [XLEN-1:0] m_rs1;
    logic [XLEN-1:0] m_rs2;
    logic            m_vld;

    always #5 clk = ~clk;

    register_file #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_valid (rd_valid),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .ready    (ready)
    );

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] model_read(input logic [AW-1:0] a, input logic we,
                                                   input logic [AW-1:0] wa, input logic [XLEN-1:0] wd);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && wa == a) return wd;
`endif
        return m_mem[a];
    endfunction

    // drive one cycle of inputs, advance one edge, update model, compare
    task automatic step(input logic r, input logic re, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd);
        bit rdy;
        rst = r; rd_en = re; rs1_addr = a1; rs2_addr = a2;
        wr_en = we; wr_addr = wa; wr_data = wd;
        @(posedge clk);
        #1;
        rdy = (m_cnt >= NREGS);
        if (r) begin
            m_cnt = 0;
            m_vld = 1'b0;
            m_rs1 = '0;
            m_rs2 = '0;
            for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
        end else begin
            if (rdy && re) begin
                m_rs1 = model_read(a1, we, wa, wd);
                m_rs2 = model_read(a2, we, wa, wd);
                m_vld = 1'b1;
            end else begin
                m_vld = 1'b0;
            end
            if (rdy && we && wa != 0) m_mem[wa] = wd;
            if (m_cnt < NREGS) m_cnt++;
        end
        check("ready", {63'b0, ready}, {63'b0, (m_cnt >= NREGS)});
        check("rd_valid", {63'b0, rd_valid}, {63'b0, m_vld});
        check("rs1_data", rs1_data, m_rs1);
        check("rs2_data", rs2_data, m_rs2);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        m_cnt = 0; m_vld = 1'b0; m_rs1 = '0; m_rs2 = '0;
        for (int i = 0; i < NREGS; i++) m_mem[i] = '0;

        // T1 / T5: reset two cycles, INIT traffic dropped, ready after 32 edges
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        check("reset_ready", {63'b0, ready}, 64'd0);
        check("reset_valid", {63'b0, rd_valid}, 64'd0);
        step(1'b0, 1'b1, 5'd9, 5'd9, 1'b1, 5'd9, 64'h99);
        check("init_valid", {63'b0, rd_valid}, 64'd0);
        idle(30);
        check("ready_edge31", {63'b0, ready}, 64'd0);
        idle(1);
        check("ready_edge32", {63'b0, ready}, 64'd1);
        step(1'b0, 1'b1, 5'd5, 5'd31, 1'b0, '0, '0);
        check("t1_rs1", rs1_data, 64'd0);
        check("t1_rs2", rs2_data, 64'd0);
        check("t1_vld", {63'b0, rd_valid}, 64'd1);
        step(1'b0, 1'b1, 5'd9, 5'd0, 1'b0, '0, '0);
        check("t5_x9", rs1_data, 64'd0);

        // T2: write then read
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 64'hDEAD_BEEF_0123_4567);
        step(1'b0, 1'b1, 5'd7, 5'd0, 1'b0, '0, '0);
        check("t2_rs1", rs1_data, 64'hDEAD_BEEF_0123_4567);
        check("t2_rs2", rs2_data, 64'd0);

        // T3: x0 write discarded
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, '0, '0);
        check("t3_x0", rs1_data, 64'd0);

        // T4: same-edge write/read collision
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 64'h11);
        step(1'b0, 1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 64'h55);
`ifdef REGFILE_BYPASS_EN
        check("t4_collide", rs1_data, 64'h55);
`else
        check("t4_collide", rs1_data, 64'h11);
`endif
        step(1'b0, 1'b1, 5'd3, 5'd0, 1'b0, '0, '0);
        check("t4_after", rs1_data, 64'h55);

        // T6: reset during RUN re-clears contents
        step(1'b0, 1'b1, '0, '0, 1'b1, 5'd4, 64'hA);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        check("t6_ready", {63'b0, ready}, 64'd0);
        check("t6_valid", {63'b0, rd_valid}, 64'd0);
        idle(NREGS);
        step(1'b0, 1'b1, 5'd4, 5'd4, 1'b0, '0, '0);
        check("t6_x4", rs1_data, 64'd0);

        // randomized traffic, addresses biased toward a small set to force collisions
        for (int i = 0; i < 1500; i++) begin
            logic [AW-1:0] a1, a2, wa;
            logic [XLEN-1:0] wd;
            logic r;
            a1 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            a2 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            wa = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            wd = {$urandom, $urandom};
            r  = ($urandom_range(0, 299) == 0);
            step(r, 1'($urandom), a1, a2, 1'($urandom), wa, wd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
